frame_task_scheduler: RTL and testbench
=======================================

# frame_task_scheduler

Per-frame update sequencer for the game logic. It consumes the one-cycle end-of-frame pulse from the frame counter and launches NUM_TASKS game-logic tasks (bird physics, pipe scroll, collision, …) strictly in order, one at a time, using a start/done handshake. It flags frames that arrive while a sequence is still running and tasks that hang. It sits between the frame counter and the per-object update blocks, so all game state changes during blanking in a fixed order.

## Interface
- NUM_TASKS, 3: number of sequenced tasks; legal range 1–8.
- TIMEOUT, 4096: maximum cycles to wait for one task's done; at least 2.
- FRAME_DIV, 1: a sequence is launched on every FRAME_DIV-th frame end; at least 1.

- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Frame_end  in  1  one-cycle end-of-frame pulse from the frame counter.
- i_Enable  in  1  gates new launches only; it never aborts a running sequence.
- i_Task_done  in  NUM_TASKS  per-task completion pulse or level; sampled only for the active task.
- i_Flag_clr  in  1  clears o_Overrun and o_Timeout.
- o_Task_start  out  NUM_TASKS  one-hot, one-cycle start pulse.
- o_Active_task  out  $clog2(NUM_TASKS) (minimum 1)  index of the current task; 0 when idle.
- o_Busy  out  1  a sequence is in progress.
- o_Seq_done  out  1  one-cycle pulse when a sequence completes normally.
- o_Overrun  out  1  sticky flag: a launching frame end arrived while busy.
- o_Timeout  out  1  sticky flag: a task exceeded TIMEOUT.
- o_Seq_count  out  16  count of normally completed sequences; wraps 0xFFFF→0.

## Operation
- FSM states:
  - IDLE: waits for a launching frame end.
  - ISSUE: o_Task_start[k]=1 for exactly this one cycle.
  - WAIT: waits for i_Task_done[k].
- Divider counter r_Div runs 0..FRAME_DIV-1.
  - It advances on every i_Frame_end while i_Enable=1, regardless of FSM state.
  - It wraps to 0 after FRAME_DIV-1.
  - A frame end is *launching* when i_Enable=1 and r_Div==0 in that cycle.
- IDLE → ISSUE with k=0 on a launching frame end.
- ISSUE → WAIT unconditionally. The timeout counter is cleared to 0 in the ISSUE cycle.
- In WAIT, when i_Task_done[k]=1:
  - If k<NUM_TASKS-1: k←k+1, go to ISSUE.
  - Otherwise: go to IDLE, pulse o_Seq_done, increment o_Seq_count.
- Done bits of non-active tasks are ignored. i_Task_done[k] asserted during ISSUE is ignored.
- The timeout counter increments on every WAIT cycle without done.
  - If it equals TIMEOUT-1 in a WAIT cycle with no done: set o_Timeout, go to IDLE.
  - The remaining tasks are skipped; there is no o_Seq_done and no count increment.
  - If done and the timeout condition coincide, done wins.
- A launching frame end while not in IDLE sets o_Overrun. That frame end is dropped, not queued.
- A launching frame end in the same cycle as the final done: the FSM is still in WAIT, so o_Overrun is set and the frame end is dropped.
- Flag clear and set in the same cycle: set wins.
- i_Enable falling mid-sequence: the sequence runs to completion; no new launches follow.
- Reset values: FSM=IDLE, k=0, r_Div=0, timeout counter=0, all outputs 0.
- Reset asserted mid-sequence aborts immediately. No o_Seq_done is generated and no start pulse is emitted during reset.

## Timing
- All outputs are registered.
- Launching i_Frame_end at cycle t: o_Task_start[0]=1 and o_Busy=1 at t+1.
- Done for task k at cycle d: o_Task_start[k+1]=1 at d+1.
- Final done at cycle d: o_Busy=0 and o_Seq_done=1 at d+1; o_Seq_count is updated at d+1.
- Minimum sequence length with immediate done: 2·NUM_TASKS cycles from start[0] to the cycle o_Busy falls.
- Timeout:
  - The first WAIT cycle is ISSUE+1.
  - The TIMEOUT-th consecutive WAIT cycle without done is the abort cycle, at ISSUE+TIMEOUT.
  - o_Timeout=1 and o_Busy=0 at the following cycle.
- o_Overrun is set the cycle after the offending frame end.
- o_Active_task changes in the same cycle as the corresponding start pulse.

## Test plan
- Nominal sequence (NUM_TASKS=3, FRAME_DIV=1): frame end at t; each done is returned 2 cycles after its start.
  - Required: starts at t+1, t+4, t+7.
  - Required: o_Seq_done at t+10; o_Seq_count goes 0→1.
- Divider (FRAME_DIV=2): 4 frame ends with i_Enable=1.
  - Required: sequences launch on the 1st and 3rd frame ends only; o_Seq_count=2.
- Timeout (TIMEOUT=16): task 1 never asserts done.
  - Required: o_Timeout=1 and o_Busy=0 17 cycles after start[1].
  - Required: start[2] never pulses and o_Seq_count is unchanged.
  - Required: i_Flag_clr then clears o_Timeout.
- Overrun: a second frame end arrives while task 0 is in WAIT.
  - Required: o_Overrun=1 on the next cycle.
  - Required: the current sequence completes normally, and no second sequence follows.
- Coincidence and ignored inputs:
  - Done on the timeout cycle → required: sequence continues and o_Timeout=0.
  - Done of a non-active task → required: ignored.
  - Final done together with a frame end → required: o_Overrun=1.
- Reset and enable:
  - i_Rst pulsed during task 1 → required: all outputs 0 immediately; the next frame end restarts at task 0.
  - i_Enable dropped mid-sequence → required: the sequence completes.

Source files
------------

// File: rtl/frame_task_scheduler.sv
// frame_task_scheduler
// Per-frame update sequencer. On a launching end-of-frame pulse it issues
// NUM_TASKS one-cycle start pulses strictly in order, waiting for each task's
// done before moving on. A frame end that launches while a sequence is still
// running raises a sticky overrun flag. A task that hangs raises a sticky
// timeout flag and abandons the rest of the sequence.

module frame_task_scheduler #(
    parameter int NUM_TASKS = 3,
    parameter int TIMEOUT   = 4096,
    parameter int FRAME_DIV = 1,
    localparam int AW = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Frame_end,
    input  logic                 i_Enable,
    input  logic [NUM_TASKS-1:0] i_Task_done,
    input  logic                 i_Flag_clr,
    output logic [NUM_TASKS-1:0] o_Task_start,
    output logic [AW-1:0]        o_Active_task,
    output logic                 o_Busy,
    output logic                 o_Seq_done,
    output logic                 o_Overrun,
    output logic                 o_Timeout,
    output logic [15:0]          o_Seq_count
);

    // Timeout counter only has to reach TIMEOUT-1; divider only FRAME_DIV-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    localparam logic [AW-1:0] K_LAST   = AW'(NUM_TASKS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // One-hot start vector for task index idx.
    function automatic logic [NUM_TASKS-1:0] task_onehot(input logic [AW-1:0] idx);
        logic [NUM_TASKS-1:0] vec;
        for (int i = 0; i < NUM_TASKS; i++) begin
            vec[i] = (idx == AW'(i));
        end
        return vec;
    endfunction

    state_t                 state_q, state_d;
    logic [AW-1:0]          k_q, k_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [DW-1:0]          div_q, div_d;
    logic [NUM_TASKS-1:0]   start_q, start_d;
    logic [AW-1:0]          active_q, active_d;
    logic                   busy_q, busy_d;
    logic                   seq_done_q, seq_done_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic [15:0]            count_q, count_d;

    logic                   launch_s;
    logic                   done_sel_s;
    logic                   overrun_set_s;
    logic                   tmo_set_s;

    // A frame end launches only when enabled and the divider sits at zero.
    assign launch_s      = i_Frame_end & i_Enable & (div_q == '0);
    assign overrun_set_s = launch_s & (state_q != ST_IDLE);

    // Select the done bit of the active task; every other bit is ignored.
    always_comb begin
        done_sel_s = 1'b0;
        for (int i = 0; i < NUM_TASKS; i++) begin
            done_sel_s = done_sel_s | (i_Task_done[i] & (k_q == AW'(i)));
        end
    end

    // Frame divider advances on every enabled frame end, in any FSM state.
    always_comb begin
        div_d = div_q;
        if (i_Frame_end && i_Enable) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DW'(1);
            end
        end else begin
            div_d = div_q;
        end
    end

    // Sequencer next state and next values of all registered outputs.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tmo_d      = tmo_q;
        start_d    = '0;
        active_d   = active_q;
        busy_d     = busy_q;
        seq_done_d = 1'b0;
        count_d    = count_q;
        tmo_set_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    state_d  = ST_ISSUE;
                    k_d      = '0;
                    start_d  = task_onehot('0);
                    active_d = '0;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // Done seen while the start pulse is out is ignored.
                state_d = ST_WAIT;
                tmo_d   = '0;
            end

            ST_WAIT: begin
                if (done_sel_s) begin
                    // Done wins over a coincident timeout.
                    if (k_q != K_LAST) begin
                        state_d  = ST_ISSUE;
                        k_d      = k_q + AW'(1);
                        start_d  = task_onehot(k_q + AW'(1));
                        active_d = k_q + AW'(1);
                    end else begin
                        state_d    = ST_IDLE;
                        k_d        = '0;
                        active_d   = '0;
                        busy_d     = 1'b0;
                        seq_done_d = 1'b1;
                        count_d    = count_q + 16'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abandon the remaining tasks of this frame.
                    tmo_set_s = 1'b1;
                    state_d   = ST_IDLE;
                    k_d       = '0;
                    tmo_d     = '0;
                    active_d  = '0;
                    busy_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                k_d      = '0;
                tmo_d    = '0;
                active_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Sticky flags: clear is overridden by a set in the same cycle.
    always_comb begin
        overrun_d = (overrun_q & ~i_Flag_clr) | overrun_set_s;
        timeout_d = (timeout_q & ~i_Flag_clr) | tmo_set_s;
    end

    // State, divider and output registers; reset aborts any running sequence.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            tmo_q      <= '0;
            div_q      <= '0;
            start_q    <= '0;
            active_q   <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            tmo_q      <= tmo_d;
            div_q      <= div_d;
            start_q    <= start_d;
            active_q   <= active_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            count_q    <= count_d;
        end
    end

    assign o_Task_start  = start_q;
    assign o_Active_task = active_q;
    assign o_Busy        = busy_q;
    assign o_Seq_done    = seq_done_q;
    assign o_Overrun     = overrun_q;
    assign o_Timeout     = timeout_q;
    assign o_Seq_count   = count_q;

endmodule

// File: tb/tb_frame_task_scheduler.sv
// Bench for frame_task_scheduler: two instances (FRAME_DIV=1 and 2, TIMEOUT=16)
// share stimulus; a behavioural model predicts every output each cycle, and
// directed scenarios add absolute timing checks.

module tb_frame_task_scheduler;

    localparam int NT  = 3;
    localparam int TMO = 16;

    logic           clk;
    logic           rst, fe, en, clr;
    logic [NT-1:0]  done;

    logic [NT-1:0]  o_start [2];
    logic [1:0]     o_act   [2];
    logic           o_busy  [2];
    logic           o_sdone [2];
    logic           o_ovr   [2];
    logic           o_tmo   [2];
    logic [15:0]    o_cnt   [2];

    int vectors    = 0;
    int miscompares = 0;

    // behavioural model state, one set per instance
    int            fdiv [2] = '{1, 2};
    int            mdiv [2];
    bit            mbusy[2];
    bit            missue[2];
    int            mtask[2];
    int            mwait[2];
    bit            movr [2];
    bit            mtmo [2];
    int            mcnt [2];
    logic [NT-1:0] mstart[2];
    bit            msdone[2];

    // stimulus / responder state
    int cyc;
    int resp_delay;
    int hang_task;
    int noise_mode;
    int due [NT];
    int last_start [NT];
    int last_sdone;
    int start2_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    frame_task_scheduler #(.NUM_TASKS(NT), .TIMEOUT(TMO), .FRAME_DIV(1)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_Frame_end(fe), .i_Enable(en),
        .i_Task_done(done), .i_Flag_clr(clr),
        .o_Task_start(o_start[0]), .o_Active_task(o_act[0]), .o_Busy(o_busy[0]),
        .o_Seq_done(o_sdone[0]), .o_Overrun(o_ovr[0]), .o_Timeout(o_tmo[0]),
        .o_Seq_count(o_cnt[0])
    );

    frame_task_scheduler #(.NUM_TASKS(NT), .TIMEOUT(TMO), .FRAME_DIV(2)) dut2 (
        .i_Clk(clk), .i_Rst(rst), .i_Frame_end(fe), .i_Enable(en),
        .i_Task_done(done), .i_Flag_clr(clr),
        .o_Task_start(o_start[1]), .o_Active_task(o_act[1]), .o_Busy(o_busy[1]),
        .o_Seq_done(o_sdone[1]), .o_Overrun(o_ovr[1]), .o_Timeout(o_tmo[1]),
        .o_Seq_count(o_cnt[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset(input int m);
        mdiv[m] = 0; mbusy[m] = 1'b0; missue[m] = 1'b0; mtask[m] = 0; mwait[m] = 0;
        movr[m] = 1'b0; mtmo[m] = 1'b0; mcnt[m] = 0; mstart[m] = '0; msdone[m] = 1'b0;
    endfunction

    // One clock of the scheduler's rules, applied to the sampled inputs.
    function automatic void model_step(input int m);
        bit launch, ovr_set, tmo_set;
        if (rst) begin
            model_reset(m);
            return;
        end
        launch = fe && en && (mdiv[m] == 0);
        if (fe && en) mdiv[m] = (mdiv[m] + 1) % fdiv[m];
        mstart[m] = '0;
        msdone[m] = 1'b0;
        ovr_set   = launch && mbusy[m];
        tmo_set   = 1'b0;
        if (!mbusy[m]) begin
            if (launch) begin
                mbusy[m] = 1'b1; mtask[m] = 0; missue[m] = 1'b1; mstart[m] = NT'(1);
            end
        end else if (missue[m]) begin
            missue[m] = 1'b0;
            mwait[m]  = 0;
        end else if (done[mtask[m]]) begin
            if (mtask[m] < NT - 1) begin
                mtask[m]  = mtask[m] + 1;
                missue[m] = 1'b1;
                mstart[m] = NT'(1) << mtask[m];
            end else begin
                mbusy[m] = 1'b0; mtask[m] = 0; msdone[m] = 1'b1;
                mcnt[m]  = (mcnt[m] + 1) % 65536;
            end
        end else begin
            mwait[m] = mwait[m] + 1;
            if (mwait[m] == TMO) begin
                tmo_set = 1'b1; mbusy[m] = 1'b0; mtask[m] = 0;
            end
        end
        movr[m] = (movr[m] && !clr) || ovr_set;
        mtmo[m] = (mtmo[m] && !clr) || tmo_set;
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("start%0d", m),  32'(o_start[m]), 32'(mstart[m]));
            check_eq($sformatf("active%0d", m), 32'(o_act[m]),   mbusy[m] ? 32'(mtask[m]) : 32'd0);
            check_eq($sformatf("busy%0d", m),   32'(o_busy[m]),  32'(mbusy[m]));
            check_eq($sformatf("seqdone%0d", m),32'(o_sdone[m]), 32'(msdone[m]));
            check_eq($sformatf("overrun%0d", m),32'(o_ovr[m]),   32'(movr[m]));
            check_eq($sformatf("timeout%0d", m),32'(o_tmo[m]),   32'(mtmo[m]));
            check_eq($sformatf("count%0d", m),  32'(o_cnt[m]),   32'(mcnt[m]));
        end
    endtask

    function automatic void clear_due();
        for (int k = 0; k < NT; k++) due[k] = -1;
    endfunction

    // One clock: drive done, step the model at the edge, compare 1 time unit later.
    task automatic tick();
        for (int k = 0; k < NT; k++) begin
            done[k] = (due[k] == cyc);
            if (noise_mode == 1 && k != mtask[0] && $urandom_range(0, 2) == 0) done[k] = 1'b1;
            if (noise_mode == 2 && $urandom_range(0, 7) == 0) done[k] = 1'b1;
        end
        @(posedge clk);
        model_step(0);
        model_step(1);
        if (rst) clear_due();
        #1;
        cyc++;
        compare_all();
        for (int k = 0; k < NT; k++) begin
            if (o_start[0][k]) last_start[k] = cyc;
            if (mstart[0][k] && k != hang_task) due[k] = cyc + resp_delay;
        end
        if (o_start[0][2]) start2_cnt++;
        if (o_sdone[0]) last_sdone = cyc;
        @(negedge clk);
        fe  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        while ((mbusy[0] || mbusy[1]) && n < 300) begin
            tick();
            n++;
        end
        check_eq("idle_bound", {31'd0, mbusy[0] | mbusy[1]}, 32'd0);
    endtask

    initial begin
        int t0, s1, c0, st2;
        rst = 1'b1; fe = 1'b0; en = 1'b1; clr = 1'b0; done = '0;
        cyc = 0; resp_delay = 2; hang_task = -1; noise_mode = 0;
        last_sdone = -1; start2_cnt = 0;
        clear_due();
        for (int k = 0; k < NT; k++) last_start[k] = -1;
        model_reset(0);
        model_reset(1);

        // reset state
        tick();
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // nominal sequence, done two cycles after each start
        fe = 1'b1; t0 = cyc;
        tick();
        run_idle();
        for (int k = 0; k < NT; k++) check_eq($sformatf("nom_start%0d_cyc", k), 32'(last_start[k]), 32'(t0 + 1 + 3 * k));
        check_eq("nom_seqdone_cyc", 32'(last_sdone), 32'(t0 + 10));
        check_eq("nom_count", 32'(o_cnt[0]), 32'd1);
        repeat (3) tick();

        // divider: three more frame ends (four in total)
        for (int i = 0; i < 3; i++) begin
            fe = 1'b1;
            tick();
            run_idle();
            repeat (3) tick();
        end
        check_eq("div_count_fd2", 32'(o_cnt[1]), 32'd2);
        check_eq("div_count_fd1", 32'(o_cnt[0]), 32'd4);

        // timeout: task 1 never answers
        hang_task = 1; last_start[1] = -1; c0 = mcnt[0]; st2 = start2_cnt;
        fe = 1'b1;
        tick();
        while (last_start[1] < 0 && cyc < t0 + 400) tick();
        s1 = last_start[1];
        while (cyc < s1 + 16) tick();
        check_eq("tmo_before_flag", 32'(o_tmo[0]), 32'd0);
        check_eq("tmo_before_busy", 32'(o_busy[0]), 32'd1);
        tick();
        check_eq("tmo_flag", 32'(o_tmo[0]), 32'd1);
        check_eq("tmo_busy", 32'(o_busy[0]), 32'd0);
        run_idle();
        repeat (4) tick();
        check_eq("tmo_no_start2", 32'(start2_cnt), 32'(st2));
        check_eq("tmo_count", 32'(o_cnt[0]), 32'(c0));
        hang_task = -1;
        clr = 1'b1;
        tick();
        check_eq("tmo_cleared", 32'(o_tmo[0]), 32'd0);

        // overrun: second frame end while task 0 waits
        resp_delay = 5; c0 = mcnt[0];
        fe = 1'b1;
        tick();
        repeat (2) tick();
        fe = 1'b1;
        tick();
        check_eq("ovr_flag", 32'(o_ovr[0]), 32'd1);
        run_idle();
        repeat (20) tick();
        check_eq("ovr_count", 32'(o_cnt[0]), 32'(c0 + 1));
        check_eq("ovr_no_second", 32'(o_busy[0]), 32'd0);
        clr = 1'b1;
        tick();

        // done coincides with the timeout cycle: done wins
        resp_delay = TMO; c0 = mcnt[0];
        fe = 1'b1;
        tick();
        run_idle();
        check_eq("coinc_tmo", 32'(o_tmo[0]), 32'd0);
        check_eq("coinc_count", 32'(o_cnt[0]), 32'(c0 + 1));
        repeat (3) tick();

        // non-active done bits are ignored
        resp_delay = 3; noise_mode = 1; c0 = mcnt[0];
        fe = 1'b1;
        tick();
        run_idle();
        noise_mode = 0;
        check_eq("noise_count", 32'(o_cnt[0]), 32'(c0 + 1));
        repeat (3) tick();

        // final done with a frame end in the same cycle
        resp_delay = 2;
        fe = 1'b1; t0 = cyc;
        tick();
        while (cyc < t0 + 9) tick();
        fe = 1'b1;
        tick();
        check_eq("final_ovr", 32'(o_ovr[0]), 32'd1);
        check_eq("final_seqdone", 32'(o_sdone[0]), 32'd1);
        run_idle();
        clr = 1'b1;
        tick();

        // reset during task 1
        resp_delay = 4;
        fe = 1'b1;
        tick();
        while (!(mbusy[0] && mtask[0] == 1) && cyc < t0 + 400) tick();
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check_eq("rst_start", 32'(o_start[0]), 32'd0);
        check_eq("rst_busy", 32'(o_busy[0]), 32'd0);
        check_eq("rst_active", 32'(o_act[0]), 32'd0);
        check_eq("rst_count", 32'(o_cnt[0]), 32'd0);
        model_reset(0);
        model_reset(1);
        clear_due();
        tick();
        rst = 1'b0;
        fe = 1'b1;
        tick();
        check_eq("rst_restart", 32'(o_start[0]), 32'd1);
        run_idle();

        // enable dropped mid-sequence
        c0 = mcnt[0];
        fe = 1'b1;
        tick();
        repeat (3) tick();
        en = 1'b0;
        fe = 1'b1;
        tick();
        run_idle();
        repeat (10) tick();
        check_eq("en_count", 32'(o_cnt[0]), 32'(c0 + 1));
        check_eq("en_no_ovr", 32'(o_ovr[0]), 32'd0);
        check_eq("en_idle", 32'(o_busy[0]), 32'd0);
        en = 1'b1;

        // randomized traffic
        noise_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                hang_task  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NT - 1)) : -1;
                resp_delay = int'($urandom_range(1, 20));
            end
            fe  = ($urandom_range(0, 9) == 0);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 400) == 0);
            tick();
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
